// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer beside the ID/EM register: load-use, memory-wait and taken-branch handling plus ALU-result forwarding.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned FLUSH_CYC      = 2,
  parameter int unsigned MAX_WAIT       = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  id_rs_addr_i,
  input  logic [2:0]  id_rt_addr_i,
  input  logic        id_uses_rs_i,
  input  logic        id_uses_rt_i,
  input  logic [2:0]  em_write_addr_i,
  input  logic        em_regwrite_i,
  input  logic        em_memread_i,
  input  logic        em_memwrite_i,
  input  logic        mem_ready_i,
  input  logic        branch_taken_i,
  output logic        stall_o,
  output logic        hold_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic        fwd_rs_o,
  output logic        fwd_rt_o,
  output logic        timeout_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_count_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  localparam logic [7:0] LD_CYC_C   = 8'(LOAD_STALL_CYC);
  localparam logic [7:0] FL_CYC_C   = 8'(FLUSH_CYC);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
  logic       timeout_r, timeout_set_s;
  logic       memop_s, hit_rs_s, hit_rt_s, lu_s;
  logic       stall_s, hold_s, bubble_s, flush_s;

  assign memop_s  = em_memread_i | em_memwrite_i;
  assign hit_rs_s = id_uses_rs_i & (id_rs_addr_i == em_write_addr_i);
  assign hit_rt_s = id_uses_rt_i & (id_rt_addr_i == em_write_addr_i);
  assign lu_s     = em_memread_i & (hit_rs_s | hit_rt_s);

  // State, counter and sticky timeout registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_RUN;
      cnt_r      <= 8'd0;
      wait_cnt_r <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      timeout_r  <= timeout_r | timeout_set_s;
    end
  end

  // Next-state and Mealy control outputs.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    stall_s        = 1'b0;
    hold_s         = 1'b0;
    bubble_s       = 1'b0;
    flush_s        = 1'b0;
    case (state_r)
      ST_RUN: begin
        // Branch outranks load-use: the dependent instruction is flushed anyway.
        if (memop_s && !mem_ready_i) begin
          stall_s        = 1'b1;
          hold_s         = 1'b1;
          state_nxt_s    = ST_MEMWAIT;
          wait_cnt_nxt_s = 8'd1;
        end else if (branch_taken_i) begin
          flush_s     = 1'b1;
          state_nxt_s = ST_FLUSH;
          cnt_nxt_s   = 8'd1;
        end else if (lu_s) begin
          stall_s     = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = ST_LDSTALL;
          cnt_nxt_s   = 8'd1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (cnt_r < LD_CYC_C) begin
          stall_s   = 1'b1;
          bubble_s  = 1'b1;
          cnt_nxt_s = cnt_r + 8'd1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ready_i) begin
          state_nxt_s = ST_RUN;
        end else if (wait_cnt_r == MAX_WAIT_C) begin
          stall_s       = 1'b1;
          hold_s        = 1'b1;
          timeout_set_s = 1'b1;
          state_nxt_s   = ST_RUN;
        end else begin
          stall_s        = 1'b1;
          hold_s         = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_FLUSH: begin
        if (branch_taken_i) begin
          flush_s   = 1'b1;
          cnt_nxt_s = 8'd1;
        end else if (cnt_r < FL_CYC_C) begin
          flush_s   = 1'b1;
          cnt_nxt_s = cnt_r + 8'd1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  assign stall_o   = stall_s;
  assign hold_o    = hold_s;
  assign bubble_o  = bubble_s;
  assign flush_o   = flush_s;
  assign timeout_o = timeout_r;
  assign state_o   = state_r;
  assign fwd_rs_o  = em_regwrite_i & ~em_memread_i & hit_rs_s & ~bubble_s;
  assign fwd_rt_o  = em_regwrite_i & ~em_memread_i & hit_rt_s & ~bubble_s;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count_o = stall_cnt_r;
`else
  assign stall_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  id_rs_addr_i, id_rt_addr_i, em_write_addr_i;
  logic        id_uses_rs_i, id_uses_rt_i;
  logic        em_regwrite_i, em_memread_i, em_memwrite_i;
  logic        mem_ready_i, branch_taken_i;
  logic        stall_o, hold_o, bubble_o, flush_o, fwd_rs_o, fwd_rt_o, timeout_o;
  logic [1:0]  state_o;
  logic [15:0] stall_count_o;

  int n_vec = 0;
  int n_miscmp = 0;
  int stall_model = 0;
  logic exp_stall_now = 1'b0;

  pipe_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .em_write_addr_i(em_write_addr_i), .em_regwrite_i(em_regwrite_i),
    .em_memread_i(em_memread_i), .em_memwrite_i(em_memwrite_i),
    .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i),
    .stall_o(stall_o), .hold_o(hold_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o), .timeout_o(timeout_o),
    .state_o(state_o), .stall_count_o(stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_stall, input logic e_hold,
                         input logic e_bubble, input logic e_flush, input logic e_frs,
                         input logic e_frt, input logic [1:0] e_state);
    #1;
    chk_val({tag, ".stall"},  16'(stall_o),  16'(e_stall));
    chk_val({tag, ".hold"},   16'(hold_o),   16'(e_hold));
    chk_val({tag, ".bubble"}, 16'(bubble_o), 16'(e_bubble));
    chk_val({tag, ".flush"},  16'(flush_o),  16'(e_flush));
    chk_val({tag, ".fwd_rs"}, 16'(fwd_rs_o), 16'(e_frs));
    chk_val({tag, ".fwd_rt"}, 16'(fwd_rt_o), 16'(e_frt));
    chk_val({tag, ".state"},  16'(state_o),  16'(e_state));
    exp_stall_now = e_stall;
  endtask

  task automatic chk_perf(input string tag);
`ifdef HAZ_PERF_CNT_EN
    chk_val(tag, stall_count_o, 16'(stall_model));
`else
    chk_val(tag, stall_count_o, 16'd0);
`endif
  endtask

  task automatic tick();
    if (rst_i) stall_model = 0;
    else if (exp_stall_now) stall_model = stall_model + 1;
    exp_stall_now = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs_addr_i = 3'd0; id_rt_addr_i = 3'd0; em_write_addr_i = 3'd0;
    id_uses_rs_i = 1'b0; id_uses_rt_i = 1'b0;
    em_regwrite_i = 1'b0; em_memread_i = 1'b0; em_memwrite_i = 1'b0;
    mem_ready_i = 1'b1; branch_taken_i = 1'b0;
  endtask

  task automatic set_lu(input logic [2:0] addr);
    em_memread_i = 1'b1; em_regwrite_i = 1'b1; em_write_addr_i = addr;
    id_rs_addr_i = addr; id_uses_rs_i = 1'b1; mem_ready_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_val("rst.timeout", 16'(timeout_o), 16'd0);
    chk_perf("rst.perf");

    // Load-use: one bubble cycle, then LDSTALL falls straight back to RUN.
    set_lu(3'd3);
    chk_out("lu.run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    idle();
    chk_out("lu.ld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    tick();
    chk_out("lu.back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_perf("lu.perf");

    // ALU forwarding patterns (combinational, no state change).
    em_regwrite_i = 1'b1; em_write_addr_i = 3'd5;
    id_rt_addr_i = 3'd5; id_uses_rt_i = 1'b1; id_rs_addr_i = 3'd2; id_uses_rs_i = 1'b1;
    chk_out("fwd.rt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    id_rs_addr_i = 3'd5; id_uses_rt_i = 1'b0;
    chk_out("fwd.rs", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    em_write_addr_i = 3'd0; id_rs_addr_i = 3'd0; id_rt_addr_i = 3'd0; id_uses_rt_i = 1'b1;
    chk_out("fwd.r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    tick();
    idle();

    // Memory wait: ready low in the RUN cycle plus four MEMWAIT cycles.
    em_memwrite_i = 1'b1; mem_ready_i = 1'b0;
    chk_out("mw.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out("mw.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      tick();
    end
    mem_ready_i = 1'b1;
    chk_out("mw.ready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    tick();
    idle();
    chk_out("mw.back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_val("mw.timeout", 16'(timeout_o), 16'd0);
    chk_perf("mw.perf");

    // Branch together with load-use: flush wins, two flush cycles.
    set_lu(3'd4); branch_taken_i = 1'b1;
    chk_out("br.run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    branch_taken_i = 1'b0;
    chk_out("br.f1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    tick();
    chk_out("br.f2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    idle();
    tick();
    chk_out("br.back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // A second branch at the last flush cycle restarts the count.
    branch_taken_i = 1'b1;
    tick();
    branch_taken_i = 1'b0;
    tick();
    branch_taken_i = 1'b1;
    chk_out("rb.re", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    tick();
    branch_taken_i = 1'b0;
    chk_out("rb.f1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    tick();
    chk_out("rb.f2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    tick();
    chk_out("rb.back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Timeout: fifteen MEMWAIT cycles with ready held low.
    em_memread_i = 1'b1; mem_ready_i = 1'b0; em_write_addr_i = 3'd7;
    chk_out("to.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk_out("to.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      chk_val("to.pre", 16'(timeout_o), 16'd0);
      tick();
    end
    chk_val("to.set", 16'(timeout_o), 16'd1);
    chk_out("to.run2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    idle();
    chk_out("to.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(); tick(); tick();
    chk_val("to.sticky", 16'(timeout_o), 16'd1);
    chk_perf("to.perf");

    // Reset in the middle of a flush.
    branch_taken_i = 1'b1;
    tick();
    branch_taken_i = 1'b0;
    chk_out("rf.f1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_out("rf.run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_val("rf.timeout", 16'(timeout_o), 16'd0);
    chk_perf("rf.perf0");
    set_lu(3'd6);
    chk_out("rf.lu", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    idle();
    chk_out("rf.ld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    tick();
    chk_perf("rf.perf1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
